// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared types, direction codes and default sizing for the elevator scheduler
package elev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

    localparam int DEF_FLOORS       = 4;
    localparam int DEF_TRAVEL_TICKS = 20;
    localparam int DEF_DOOR_TICKS   = 30;

    // Width of one counter able to hold either terminal value.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/elev_scheduler_if.sv
// rtl/elev_scheduler_if.sv - request/status bundle between panel logic and the scheduler
interface elev_scheduler_if
    import elev_pkg::*;
#(
    parameter int FLOORS = DEF_FLOORS
);
    localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

    logic                tick;
    logic                power;
    logic [FLOORS-1:0]   req_cab;
    logic [FLOORS-1:0]   req_up;
    logic [FLOORS-1:0]   req_dn;
    logic [FW-1:0]       cur_floor;
    logic [1:0]          dir;
    logic                door_open;
    logic                arrive;
    logic [3*FLOORS-1:0] pend_led;

    modport master (
        output tick, power, req_cab, req_up, req_dn,
        input  cur_floor, dir, door_open, arrive, pend_led
    );

    modport slave (
        input  tick, power, req_cab, req_up, req_dn,
        output cur_floor, dir, door_open, arrive, pend_led
    );

endinterface

// File: rtl/elev_tick_timer.sv
// rtl/elev_tick_timer.sv - tick-enabled counter with clear and terminal-count strobe
module elev_tick_timer #(
    parameter int W = 5
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    // tc marks the tick that brings the count up to limit; the counter wraps to 0 there.
    assign tc = tick && !clr && (count == (limit - W'(1)));

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/elev_scheduler.sv
// rtl/elev_scheduler.sv - single-car elevator scheduler: pending lamps, sweep direction, travel and door timing
module elev_scheduler
    import elev_pkg::*;
#(
    parameter int FLOORS       = DEF_FLOORS,
    parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int DOOR_TICKS   = DEF_DOOR_TICKS
) (
    input  logic            clkin,
    input  logic            reset,
    elev_scheduler_if.slave bus
);

    localparam int CW = cnt_width(TRAVEL_TICKS, DOOR_TICKS);
    localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
    localparam logic [FLOORS-1:0] ALL   = '1;
    localparam logic [FLOORS-1:0] ONE   = FLOORS'(1);
    localparam logic [FLOORS-1:0] UP_OK = ALL >> 1;
    localparam logic [FLOORS-1:0] DN_OK = ALL << 1;
    localparam logic [FW-1:0]     TOP   = FW'(FLOORS - 1);

    state_t            state, state_nx;
    logic [FW-1:0]     floor_q, floor_nx;
    logic [1:0]        dir_q, dir_nx;
    logic [FLOORS-1:0] pend_cab, pend_up, pend_dn, pend_any;
    logic              arrive_q, ready_q;
    logic              tmr_tick, tmr_clr, tmr_tc;
    logic [CW-1:0]     tmr_limit;
    logic              step, stop, door_restart;
    logic              req_here, stop_here, no_beyond, going_up;
    logic [FLOORS-1:0] req_up_m, req_dn_m, cur_oh, nxt_oh;
    logic [FLOORS-1:0] above_cur, below_cur, beyond_nxt, hold_here;
    logic [FLOORS-1:0] clr_cab, clr_up, clr_dn;

    assign going_up  = (dir_q == DIR_UP);
    assign req_up_m  = bus.req_up & UP_OK;
    assign req_dn_m  = bus.req_dn & DN_OK;
    assign cur_oh    = ONE << floor_q;
    assign above_cur = (ALL << floor_q) << 1;
    assign below_cur = ~(ALL << floor_q);
    assign pend_any  = pend_cab | pend_up | pend_dn;
    assign req_here  = |((bus.req_cab | req_up_m | req_dn_m) & cur_oh);
    // Outside MOVE a call for the car's own floor is served by the door, never lamped.
    assign hold_here = (state == ST_MOVE) ? '0 : cur_oh;

    always_comb begin
        floor_nx = floor_q;
        if (dir_q == DIR_UP && floor_q != TOP) begin
            floor_nx = floor_q + FW'(1);
        end else if (dir_q == DIR_DN && floor_q != '0) begin
            floor_nx = floor_q - FW'(1);
        end
    end

    assign nxt_oh     = ONE << floor_nx;
    assign beyond_nxt = going_up ? ((ALL << floor_nx) << 1) : ~(ALL << floor_nx);
    assign no_beyond  = ~|(pend_any & beyond_nxt);
    assign stop_here  = (|(pend_cab & nxt_oh)) ||
                        (|((going_up ? pend_up : pend_dn) & nxt_oh)) || no_beyond;

    assign clr_cab = stop ? nxt_oh : '0;
    assign clr_up  = (stop && (going_up || no_beyond))  ? nxt_oh : '0;
    assign clr_dn  = (stop && (!going_up || no_beyond)) ? nxt_oh : '0;

    assign tmr_tick  = bus.tick && bus.power && (state != ST_IDLE);
    assign tmr_clr   = !bus.power || (state == ST_IDLE) || door_restart;
    assign tmr_limit = (state == ST_MOVE) ? CW'(TRAVEL_TICKS) : CW'(DOOR_TICKS);

    elev_tick_timer #(.W(CW)) u_timer (
        .clkin (clkin),
        .reset (reset),
        .tick  (tmr_tick),
        .clr   (tmr_clr),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        dir_nx       = dir_q;
        step         = 1'b0;
        stop         = 1'b0;
        door_restart = 1'b0;
        if (!bus.power) begin
            state_nx = ST_IDLE;
            dir_nx   = DIR_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready_q) begin
                        if (req_here) begin
                            state_nx = ST_DOOR;
                        end else if (dir_q == DIR_UP && |(pend_any & above_cur)) begin
                            state_nx = ST_MOVE;
                        end else if (dir_q == DIR_DN && |(pend_any & below_cur)) begin
                            state_nx = ST_MOVE;
                        end else if (|(pend_any & above_cur)) begin
                            dir_nx   = DIR_UP;
                            state_nx = ST_MOVE;
                        end else if (|(pend_any & below_cur)) begin
                            dir_nx   = DIR_DN;
                            state_nx = ST_MOVE;
                        end else begin
                            dir_nx = DIR_IDLE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (tmr_tc) begin
                        step = 1'b1;
                        if (stop_here) begin
                            stop     = 1'b1;
                            state_nx = ST_DOOR;
                        end
                    end
                end
                ST_DOOR: begin
                    if (req_here) begin
                        door_restart = 1'b1;
                    end else if (tmr_tc) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.door_open = (state == ST_DOOR);
        bus.arrive    = arrive_q;
        bus.cur_floor = floor_q;
        bus.dir       = dir_q;
        bus.pend_led  = {pend_dn, pend_up, pend_cab};
    end

    // ready_q holds off the first decision until the second edge after reset release.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            dir_q    <= DIR_IDLE;
            arrive_q <= 1'b0;
            floor_q  <= '0;
            pend_cab <= '0;
            pend_up  <= '0;
            pend_dn  <= '0;
        end else begin
            ready_q  <= 1'b1;
            dir_q    <= dir_nx;
            arrive_q <= step;
            if (step) begin
                floor_q <= floor_nx;
            end
            if (!bus.power) begin
                pend_cab <= '0;
                pend_up  <= '0;
                pend_dn  <= '0;
            end else begin
                pend_cab <= (pend_cab | (bus.req_cab & ~hold_here)) & ~clr_cab;
                pend_up  <= (pend_up  | (req_up_m    & ~hold_here)) & ~clr_up;
                pend_dn  <= (pend_dn  | (req_dn_m    & ~hold_here)) & ~clr_dn;
            end
        end
    end

endmodule
